// File: rtl/spr_arbiter.sv
// Two-requester round-robin arbiter that sequences single-port RAM commands
// (00 waddr, 01 wdata, 10 raddr, 11 rdata). Optional `define ADDR_CACHE_EN skips repeated address phases.
module spr_arbiter #(
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [7:0]           wdata0,
  output logic                 ack0,
  output logic [7:0]           rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [7:0]           wdata1,
  output logic                 ack1,
  output logic [7:0]           rdata1,
  output logic                 err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WDATA, S_RADDR, S_RCMD, S_RWAIT, S_ACK
  } state_e;

  // Last RWAIT cycle before the read is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   gnt_q, gnt_d;
  logic                   rr_q, rr_d;
  logic                   we_q, we_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   err_q, err_d;
  logic [7:0]             rdata0_q, rdata0_d;
  logic [7:0]             rdata1_q, rdata1_d;
  logic [9:0]             ram_din_q, ram_din_d;
  logic                   ram_rx_valid_q, ram_rx_valid_d;
  logic                   busy_q, busy_d;

  logic                   sel;
  logic                   sel_we;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [7:0]             sel_wdata;
  logic                   whit;
  logic                   rhit;

  // Requester selection: a lone request wins, a tie goes to rr_q.
  always_comb begin
    sel       = (req0 && req1) ? rr_q : req1;
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
  end

`ifdef ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] last_waddr_q, last_waddr_d;
  logic                 last_waddr_vld_q, last_waddr_vld_d;
  logic [ADDR_SIZE-1:0] last_raddr_q, last_raddr_d;
  logic                 last_raddr_vld_q, last_raddr_vld_d;

  assign whit = last_waddr_vld_q && (sel_addr == last_waddr_q);
  assign rhit = last_raddr_vld_q && (sel_addr == last_raddr_q);

  // The RAM keeps its own address registers, so remember what it last received.
  always_comb begin
    last_waddr_d     = last_waddr_q;
    last_waddr_vld_d = last_waddr_vld_q;
    last_raddr_d     = last_raddr_q;
    last_raddr_vld_d = last_raddr_vld_q;
    if (state_q == S_IDLE && state_d == S_WADDR) begin
      last_waddr_d     = addr_d;
      last_waddr_vld_d = 1'b1;
    end
    if (state_q == S_IDLE && state_d == S_RADDR) begin
      last_raddr_d     = addr_d;
      last_raddr_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_waddr_q     <= '0;
      last_waddr_vld_q <= 1'b0;
      last_raddr_q     <= '0;
      last_raddr_vld_q <= 1'b0;
    end else begin
      last_waddr_q     <= last_waddr_d;
      last_waddr_vld_q <= last_waddr_vld_d;
      last_raddr_q     <= last_raddr_d;
      last_raddr_vld_q <= last_raddr_vld_d;
    end
  end
`else
  assign whit = 1'b0;
  assign rhit = 1'b0;
`endif

  // Next state and the internal transaction registers.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          rr_d    = ~sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_we) state_d = whit ? S_WDATA : S_WADDR;
          else        state_d = rhit ? S_RCMD  : S_RADDR;
        end
      end
      S_WADDR: state_d = S_WDATA;
      S_WDATA: state_d = S_ACK;
      S_RADDR: state_d = S_RCMD;
      S_RCMD: begin
        state_d = S_RWAIT;
        cnt_d   = '0;
      end
      S_RWAIT: begin
        if (ram_tx_valid) begin
          state_d = S_ACK;
          cnt_d   = '0;
          if (gnt_q) rdata1_d = ram_dout;
          else       rdata0_d = ram_dout;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ACK;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (gnt_q) rdata1_d = 8'h00;
          else       rdata0_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with it.
  always_comb begin
    ack0_d         = (state_d == S_ACK) && !gnt_d;
    ack1_d         = (state_d == S_ACK) &&  gnt_d;
    busy_d         = (state_d != S_IDLE);
    ram_rx_valid_d = 1'b0;
    ram_din_d      = 10'h000;
    case (state_d)
      S_WADDR: begin ram_rx_valid_d = 1'b1; ram_din_d = {2'b00, addr_d};  end
      S_WDATA: begin ram_rx_valid_d = 1'b1; ram_din_d = {2'b01, wdata_d}; end
      S_RADDR: begin ram_rx_valid_d = 1'b1; ram_din_d = {2'b10, addr_d};  end
      S_RCMD:  begin ram_rx_valid_d = 1'b1; ram_din_d = {2'b11, 8'h00};   end
      default: begin ram_rx_valid_d = 1'b0; ram_din_d = 10'h000;          end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      gnt_q          <= 1'b0;
      rr_q           <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      err_q          <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_q           <= rr_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      err_q          <= err_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign err          = err_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spr_arbiter.sv
// Scoreboard bench for spr_arbiter: drivers queue expected RAM commands and acks,
// a monitor pops and compares them. Honours `define ADDR_CACHE_EN.
module tb_spr_arbiter;

  localparam int TO = 6;
`ifdef ADDR_CACHE_EN
  localparam bit C = 1'b1;
`else
  localparam bit C = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, err, ram_rx_valid, busy;
  logic [7:0] rdata0, rdata1;
  logic [9:0] ram_din;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  spr_arbiter #(.ADDR_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err(err), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: one-cycle tx_valid after the 11 command unless muted.
  logic [7:0] mem [256];
  logic [7:0] ram_waddr, ram_raddr;
  bit         ram_mute = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_tx_valid <= 1'b0;
      ram_dout     <= 8'h00;
      ram_waddr    <= 8'h00;
      ram_raddr    <= 8'h00;
    end else begin
      ram_tx_valid <= 1'b0;
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00: ram_waddr <= ram_din[7:0];
          2'b01: mem[ram_waddr] <= ram_din[7:0];
          2'b10: ram_raddr <= ram_din[7:0];
          default: if (!ram_mute) begin
            ram_tx_valid <= 1'b1;
            ram_dout     <= mem[ram_raddr];
          end
        endcase
      end
    end
  end

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] rdata;
    bit         err;
  } ack_t;

  ack_t       exp0[$];
  ack_t       exp1[$];
  logic [9:0] cmd_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_ack(input string nm, input ack_t e, input logic [7:0] rd);
    chk({nm, "_cycle"}, cyc, e.cyc);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, e.err});
    if (e.rd) chk({nm, "_rdata"}, {24'd0, rd}, {24'd0, e.rdata});
  endtask

  task automatic monitor();
    ack_t e;
    forever begin
      @(negedge clk);
      if (ram_rx_valid) begin
        if (cmd_q.size() == 0) chk("ram_cmd_unexpected", {22'd0, ram_din}, 32'hFFFF_FFFF);
        else chk("ram_cmd", {22'd0, ram_din}, {22'd0, cmd_q.pop_front()});
      end
      if (ack0 && ack1) chk("ack_overlap", 32'd1, 32'd0);
      if (err && !ack0 && !ack1) chk("err_without_ack", 32'd1, 32'd0);
      if (ack0) begin
        if (exp0.size() == 0) chk("ack0_unexpected", {31'd0, ack0}, 32'd0);
        else begin e = exp0.pop_front(); chk_ack("ack0", e, rdata0); end
      end
      if (ack1) begin
        if (exp1.size() == 0) chk("ack1_unexpected", {31'd0, ack1}, 32'd0);
        else begin e = exp1.pop_front(); chk_ack("ack1", e, rdata1); end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ack0"}, {31'd0, ack0}, 32'd0);
    chk({nm, "_ack1"}, {31'd0, ack1}, 32'd0);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
    chk({nm, "_rxv"}, {31'd0, ram_rx_valid}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_din"}, {22'd0, ram_din}, 32'd0);
    chk({nm, "_rdata0"}, {24'd0, rdata0}, 32'd0);
    chk({nm, "_rdata1"}, {24'd0, rdata1}, 32'd0);
  endtask

  // Called at #1 after a rising edge; the DUT (idle) samples req in this cycle
  // plus 'extra'. 'hit' is the hand-derived address-cache outcome.
  task automatic txn(input int id, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit exp_err, input bit hit,
                     input int extra, input bit hold, input bit scramble);
    ack_t e;
    int   lat;
    int   t0;
    bit   got;
    t0 = cyc;
    if (w) lat = hit ? 2 : 3;
    else if (exp_err) lat = (hit ? 2 : 3) + TO;
    else lat = hit ? 3 : 4;
    e.cyc = t0 + extra + lat; e.rd = !w; e.rdata = exp_rd; e.err = exp_err;
    if (id == 0) begin
      exp0.push_back(e); req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      exp1.push_back(e); req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    repeat (extra) begin @(posedge clk); #1; end
    if (w) begin
      if (!hit) cmd_q.push_back({2'b00, a});
      cmd_q.push_back({2'b01, d});
    end else begin
      if (!hit) cmd_q.push_back({2'b10, a});
      cmd_q.push_back({2'b11, 8'h00});
    end
    got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      @(posedge clk); #1;
      if (scramble && n == 0 && id == 0) begin
        we0 = ~w; addr0 = ~a; wdata0 = ~d;
      end
      got = (id == 0) ? ack0 : ack1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wait%0d: no ack within 80 cycles, one required", id);
    end
    if (!hold) begin
      @(posedge clk); #1;
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back one location, inputs scrambled mid-read.
    txn(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Fresh reset so the round-robin pointer starts on requester 0.
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;

    // Simultaneous requests, three rounds: grants alternate 0,1.
    fork
      txn(0, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      txn(1, 1'b1, 8'h21, 8'h22, 8'h00, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    join
    fork
      txn(0, 1'b1, 8'h20, 8'h33, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      txn(1, 1'b1, 8'h21, 8'h44, 8'h00, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    join
    fork
      txn(0, 1'b0, 8'h20, 8'h00, 8'h33, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      txn(1, 1'b0, 8'h21, 8'h00, 8'h44, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    join

    // Read timeout, then a normal read of the same address.
    ram_mute = 1'b1;
    txn(0, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    ram_mute = 1'b0;
    txn(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, C, 0, 1'b0, 1'b0);

    // Reset while the 11 command is on the bus: no ack, outputs cleared at once.
    if (!C) cmd_q.push_back({2'b10, 8'h3C});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
    repeat (C ? 1 : 2) begin @(posedge clk); #1; end
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Repeated addresses: second of each pair hits the cache when enabled.
    txn(0, 1'b1, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h10, 8'h22, 8'h00, 1'b0, C,    0, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h10, 8'h00, 8'h22, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h10, 8'h00, 8'h22, 1'b0, C,    0, 1'b0, 1'b0);

    // Held req1: exactly one idle cycle between the two transactions.
    txn(1, 1'b1, 8'h40, 8'h77, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("held_busy_ack", {31'd0, busy}, 32'd1);
    fork
      txn(1, 1'b1, 8'h41, 8'h88, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      begin
        @(posedge clk); #1; chk("held_busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; chk("held_busy_next", {31'd0, busy}, 32'd1);
      end
    join
    txn(1, 1'b0, 8'h41, 8'h00, 8'h88, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    repeat (4) @(posedge clk); #1;
    chk("cmd_left", cmd_q.size(), 32'd0);
    chk("exp0_left", exp0.size(), 32'd0);
    chk("exp1_left", exp1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
